// File: rtl/core_ctrl.sv
// Multi-core control: per-core saturating run-state, wake-PC routing,
// shared write/read port arbitration and a sticky all-halted flag.
module core_ctrl #(
    parameter int NCORES  = 4,
    parameter int PCW     = 16,
    parameter int RS_MAX  = 2,
    parameter int RS_INIT = 1,
    parameter int ARB_RR  = 0,
    localparam int CW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCORES-1:0]     wake_vld,
    input  logic [NCORES*CW-1:0]  wake_tgt,
    input  logic [NCORES*PCW-1:0] wake_pc,
    input  logic [NCORES-1:0]     pr_vld,
    input  logic [NCORES-1:0]     pr_resume,
    input  logic [NCORES*CW-1:0]  pr_tgt,
    input  logic [NCORES-1:0]     wr_req,
    input  logic [NCORES-1:0]     rd_req,
    input  logic [NCORES-1:0]     halted,
    input  logic [NCORES-1:0]     awake,
    output logic [NCORES-1:0]     start_vld,
    output logic [NCORES*PCW-1:0] start_pc,
    output logic [NCORES-1:0]     wake_ack,
    output logic [NCORES*3-1:0]   stall_num,
    output logic [NCORES-1:0]     wr_gnt,
    output logic [NCORES-1:0]     rd_gnt,
    output logic                  all_halt
);

    localparam int RSW = (RS_MAX > 1) ? $clog2(RS_MAX + 1) : 1;
    localparam int SW  = RSW + CW + 2;

    logic [RSW-1:0]    r_runState [NCORES];
    logic              r_firstCycle;
    logic              r_allHalt;
    logic [CW-1:0]     r_wrPtr;
    logic [CW-1:0]     r_rdPtr;

    logic [SW-1:0]     w_sum      [NCORES];
    logic [RSW-1:0]    w_runNext  [NCORES];
    logic [NCORES-1:0] w_paused;
    logic [NCORES-1:0] w_wrElig;
    logic [NCORES-1:0] w_rdElig;
    logic [NCORES-1:0] w_wrGnt;
    logic [NCORES-1:0] w_rdGnt;
    logic [CW-1:0]     w_wrPtrNext;
    logic [CW-1:0]     w_rdPtrNext;
    logic              w_allIdle;

    // First eligible index at or after ptr; a zero ptr gives fixed priority.
    function automatic logic [NCORES-1:0] arbPick(input logic [NCORES-1:0] req,
                                                  input logic [CW-1:0]     ptr);
        logic [NCORES-1:0] gnt;
        logic              found;
        int                idx;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            idx = (int'(ptr) + k) % NCORES;
            if (!found && req[CW'(idx)]) begin
                gnt[CW'(idx)] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [CW-1:0] ptrAfter(input logic [NCORES-1:0] gnt,
                                               input logic [CW-1:0]     ptr);
        logic [CW-1:0] p;
        p = ptr;
        for (int i = 0; i < NCORES; i++) begin
            if (gnt[i]) p = CW'((i + 1) % NCORES);
        end
        return p;
    endfunction

    // Sum is kept two's complement so the clamp can test the sign bit directly.
    always_comb begin
        for (int t = 0; t < NCORES; t++) begin
            w_sum[t] = SW'(r_runState[t]);
            for (int s = 0; s < NCORES; s++) begin
                if (pr_vld[s] && (pr_tgt[s*CW +: CW] == CW'(t))) begin
                    w_sum[t] = pr_resume[s] ? (w_sum[t] + SW'(1)) : (w_sum[t] - SW'(1));
                end
            end
            if (w_sum[t][SW-1])
                w_runNext[t] = '0;
            else if (w_sum[t] > SW'(RS_MAX))
                w_runNext[t] = RSW'(RS_MAX);
            else
                w_runNext[t] = w_sum[t][RSW-1:0];
            w_paused[t] = (r_runState[t] == '0);
        end
    end

    always_comb begin
        start_vld = '0;
        start_pc  = '0;
        wake_ack  = '0;
        if (r_firstCycle) begin
            start_vld[0] = 1'b1;
        end else begin
            for (int t = 0; t < NCORES; t++) begin
                for (int s = 0; s < NCORES; s++) begin
                    if (!start_vld[t] && wake_vld[s] && (wake_tgt[s*CW +: CW] == CW'(t))) begin
                        start_vld[t]            = 1'b1;
                        start_pc[t*PCW +: PCW]  = wake_pc[s*PCW +: PCW];
                        wake_ack[s]             = 1'b1;
                    end
                end
            end
        end
    end

    assign w_wrElig    = wr_req & ~w_paused;
    assign w_rdElig    = rd_req & ~w_paused;
    assign w_wrGnt     = arbPick(w_wrElig, (ARB_RR != 0) ? r_wrPtr : '0);
    assign w_rdGnt     = arbPick(w_rdElig, (ARB_RR != 0) ? r_rdPtr : '0);
    assign w_wrPtrNext = ptrAfter(w_wrGnt, r_wrPtr);
    assign w_rdPtrNext = ptrAfter(w_rdGnt, r_rdPtr);
    assign wr_gnt      = w_wrGnt;
    assign rd_gnt      = w_rdGnt;

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            if (w_paused[i] || (wr_req[i] && !w_wrGnt[i]))
                stall_num[i*3 +: 3] = 3'd6;
            else if (rd_req[i] && !w_rdGnt[i])
                stall_num[i*3 +: 3] = 3'd4;
            else
                stall_num[i*3 +: 3] = 3'd0;
        end
    end

    assign w_allIdle = &(halted | ~awake);
    assign all_halt  = r_allHalt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NCORES; t++) r_runState[t] <= RSW'(RS_INIT);
            r_firstCycle <= 1'b1;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_allHalt    <= 1'b0;
        end else begin
            for (int t = 0; t < NCORES; t++) r_runState[t] <= w_runNext[t];
            r_firstCycle <= 1'b0;
            if (ARB_RR != 0) begin
                r_wrPtr <= w_wrPtrNext;
                r_rdPtr <= w_rdPtrNext;
            end
            r_allHalt <= r_allHalt | w_allIdle;
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: one fixed-priority and one round-robin
// instance share stimulus and are compared against a behavioural model.
module tb_core_ctrl;

    localparam int N      = 4;
    localparam int PCW    = 16;
    localparam int RSMAX  = 2;
    localparam int RSINIT = 1;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     wake_vld;
    logic [N*2-1:0]   wake_tgt;
    logic [N*PCW-1:0] wake_pc;
    logic [N-1:0]     pr_vld;
    logic [N-1:0]     pr_resume;
    logic [N*2-1:0]   pr_tgt;
    logic [N-1:0]     wr_req;
    logic [N-1:0]     rd_req;
    logic [N-1:0]     halted;
    logic [N-1:0]     awake;

    logic [N-1:0]     oStartVld [2];
    logic [N*PCW-1:0] oStartPc  [2];
    logic [N-1:0]     oWakeAck  [2];
    logic [N*3-1:0]   oStall    [2];
    logic [N-1:0]     oWrGnt    [2];
    logic [N-1:0]     oRdGnt    [2];
    logic             oAllHalt  [2];

    int checks   = 0;
    int failures = 0;

    int mRun [N];
    int mWrPtr;
    int mRdPtr;
    bit mFirst;
    bit mAllHalt;

    logic [N-1:0]     eStartVld;
    logic [N*PCW-1:0] eStartPc;
    logic [N-1:0]     eWakeAck;
    logic [N-1:0]     eWrGnt [2];
    logic [N-1:0]     eRdGnt [2];
    logic [N*3-1:0]   eStall [2];

    core_ctrl #(.NCORES(N), .PCW(PCW), .RS_MAX(RSMAX), .RS_INIT(RSINIT), .ARB_RR(0)) dutFix (
        .clk(clk), .rst_n(rst_n), .wake_vld(wake_vld), .wake_tgt(wake_tgt), .wake_pc(wake_pc),
        .pr_vld(pr_vld), .pr_resume(pr_resume), .pr_tgt(pr_tgt), .wr_req(wr_req), .rd_req(rd_req),
        .halted(halted), .awake(awake), .start_vld(oStartVld[0]), .start_pc(oStartPc[0]),
        .wake_ack(oWakeAck[0]), .stall_num(oStall[0]), .wr_gnt(oWrGnt[0]), .rd_gnt(oRdGnt[0]),
        .all_halt(oAllHalt[0])
    );

    core_ctrl #(.NCORES(N), .PCW(PCW), .RS_MAX(RSMAX), .RS_INIT(RSINIT), .ARB_RR(1)) dutRr (
        .clk(clk), .rst_n(rst_n), .wake_vld(wake_vld), .wake_tgt(wake_tgt), .wake_pc(wake_pc),
        .pr_vld(pr_vld), .pr_resume(pr_resume), .pr_tgt(pr_tgt), .wr_req(wr_req), .rd_req(rd_req),
        .halted(halted), .awake(awake), .start_vld(oStartVld[1]), .start_pc(oStartPc[1]),
        .wake_ack(oWakeAck[1]), .stall_num(oStall[1]), .wr_gnt(oWrGnt[1]), .rd_gnt(oRdGnt[1]),
        .all_halt(oAllHalt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int pickWinner(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (req[idx] && mRun[idx] > 0) return idx;
        end
        return -1;
    endfunction

    task automatic modelEval();
        int w;
        int r;
        eStartVld = '0;
        eStartPc  = '0;
        eWakeAck  = '0;
        if (mFirst) begin
            eStartVld[0] = 1'b1;
        end else begin
            for (int t = 0; t < N; t++)
                for (int s = 0; s < N; s++)
                    if (!eStartVld[t] && wake_vld[s] && int'(wake_tgt[s*2 +: 2]) == t) begin
                        eStartVld[t]           = 1'b1;
                        eStartPc[t*PCW +: PCW] = wake_pc[s*PCW +: PCW];
                        eWakeAck[s]            = 1'b1;
                    end
        end
        for (int m = 0; m < 2; m++) begin
            w = pickWinner(wr_req, (m == 1) ? mWrPtr : 0);
            r = pickWinner(rd_req, (m == 1) ? mRdPtr : 0);
            eWrGnt[m] = (w >= 0) ? N'(1 << w) : '0;
            eRdGnt[m] = (r >= 0) ? N'(1 << r) : '0;
            for (int i = 0; i < N; i++) begin
                if (mRun[i] == 0)             eStall[m][i*3 +: 3] = 3'd6;
                else if (wr_req[i] && w != i) eStall[m][i*3 +: 3] = 3'd6;
                else if (rd_req[i] && r != i) eStall[m][i*3 +: 3] = 3'd4;
                else                          eStall[m][i*3 +: 3] = 3'd0;
            end
        end
    endtask

    task automatic modelClock();
        int w;
        int r;
        int d;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mRun[i] = RSINIT;
            mFirst   = 1'b1;
            mWrPtr   = 0;
            mRdPtr   = 0;
            mAllHalt = 1'b0;
        end else begin
            w = pickWinner(wr_req, mWrPtr);
            r = pickWinner(rd_req, mRdPtr);
            if (w >= 0) mWrPtr = (w + 1) % N;
            if (r >= 0) mRdPtr = (r + 1) % N;
            for (int t = 0; t < N; t++) begin
                d = 0;
                for (int s = 0; s < N; s++)
                    if (pr_vld[s] && int'(pr_tgt[s*2 +: 2]) == t) d += pr_resume[s] ? 1 : -1;
                d = mRun[t] + d;
                mRun[t] = (d < 0) ? 0 : (d > RSMAX) ? RSMAX : d;
            end
            if ((halted | ~awake) == 4'hF) mAllHalt = 1'b1;
            mFirst = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        wake_vld  = '0;
        wake_tgt  = '0;
        wake_pc   = '0;
        pr_vld    = '0;
        pr_resume = '0;
        pr_tgt    = '0;
        wr_req    = '0;
        rd_req    = '0;
        halted    = '0;
        awake     = 4'b1111;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        tick();
        tick();
        rst_n = 1'b1;
        wake_vld = 4'b0100;
        wake_tgt[4 +: 2] = 2'd3;
        wake_pc[32 +: 16] = 16'h1234;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStartVld[m] !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL boot_start_vld dut%0d got=%b want=0001", m, oStartVld[m]);
            end
            checks++;
            if (oStartPc[m] !== '0) begin
                failures++;
                $display("[TB] FAIL boot_start_pc dut%0d got=%h want=0", m, oStartPc[m]);
            end
            checks++;
            if (oWakeAck[m] !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL boot_wake_ack dut%0d got=%b want=0000", m, oWakeAck[m]);
            end
            checks++;
            if (oStall[m] !== 12'd0) begin
                failures++;
                $display("[TB] FAIL reset_stall dut%0d got=%h want=000", m, oStall[m]);
            end
        end
        tick();
        wake_vld = '0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStartVld[m] !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL post_boot_start_vld dut%0d got=%b want=0000", m, oStartVld[m]);
            end
            checks++;
            if (oAllHalt[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_all_halt dut%0d got=%b want=0", m, oAllHalt[m]);
            end
        end
        wake_vld = 4'b0100;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStartVld[m] !== 4'b1000 || oStartPc[m][48 +: 16] !== 16'h1234 || oWakeAck[m] !== 4'b0100) begin
                failures++;
                $display("[TB] FAIL post_boot_wake dut%0d got vld=%b pc=%h ack=%b want vld=1000 pc=1234 ack=0100",
                         m, oStartVld[m], oStartPc[m][48 +: 16], oWakeAck[m]);
            end
        end
        tick();
        clearInputs();
    endtask

    task automatic test_wake();
        wake_vld = 4'b1010;
        wake_tgt[2 +: 2] = 2'd2;
        wake_tgt[6 +: 2] = 2'd2;
        wake_pc[16 +: 16] = 16'h0040;
        wake_pc[48 +: 16] = 16'h0080;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStartVld[m] !== 4'b0100 || oStartPc[m][32 +: 16] !== 16'h0040 || oWakeAck[m] !== 4'b0010) begin
                failures++;
                $display("[TB] FAIL wake_conflict dut%0d got vld=%b pc2=%h ack=%b want vld=0100 pc2=0040 ack=0010",
                         m, oStartVld[m], oStartPc[m][32 +: 16], oWakeAck[m]);
            end
        end
        tick();
        wake_vld = 4'b1000;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStartVld[m] !== 4'b0100 || oStartPc[m][32 +: 16] !== 16'h0080 || oWakeAck[m] !== 4'b1000) begin
                failures++;
                $display("[TB] FAIL wake_retry dut%0d got vld=%b pc2=%h ack=%b want vld=0100 pc2=0080 ack=1000",
                         m, oStartVld[m], oStartPc[m][32 +: 16], oWakeAck[m]);
            end
        end
        tick();
        clearInputs();
        wake_vld = 4'b0111;
        wake_tgt = {2'd0, 2'd3, 2'd1, 2'd1};
        wake_pc  = {16'h0000, 16'h0033, 16'h0022, 16'h0011};
        #1;
        modelEval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStartVld[m] !== 4'b1010 || oStartPc[m] !== eStartPc || oWakeAck[m] !== 4'b0101) begin
                failures++;
                $display("[TB] FAIL wake_multi dut%0d got vld=%b pc=%h ack=%b want vld=1010 pc=%h ack=0101",
                         m, oStartVld[m], oStartPc[m], oWakeAck[m], eStartPc);
            end
        end
        tick();
        clearInputs();
    endtask

    task automatic test_pause_resume();
        logic [N-1:0] vldT [8];
        logic [N-1:0] resT [8];
        logic [2:0]   expT [8];
        logic [2:0]   prevExp;
        vldT = '{4'b0101, 4'b0001, 4'b1000, 4'b1101, 4'b0011, 4'b0001, 4'b0001, 4'b0001};
        resT = '{4'b0000, 4'b0000, 4'b1000, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
        expT = '{3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0};
        prevExp = 3'd0;
        pr_tgt = 8'b01_01_01_01;
        for (int k = 0; k < 8; k++) begin
            pr_vld    = vldT[k];
            pr_resume = resT[k];
            #1;
            modelEval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (oStall[m][3 +: 3] !== prevExp || oStall[m] !== eStall[m]) begin
                    failures++;
                    $display("[TB] FAIL pause_resume step%0d dut%0d got=%h want=%h core1=%0d",
                             k, m, oStall[m], eStall[m], prevExp);
                end
            end
            prevExp = expT[k];
            tick();
        end
        clearInputs();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oStall[m][3 +: 3] !== prevExp) begin
                failures++;
                $display("[TB] FAIL pause_resume_final dut%0d got=%0d want=%0d", m, oStall[m][3 +: 3], prevExp);
            end
        end
    endtask

    task automatic test_fixed_arb();
        wr_req = 4'b1111;
        #1;
        modelEval();
        checks++;
        if (oWrGnt[0] !== 4'b0001 || oStall[0] !== {3'd6, 3'd6, 3'd6, 3'd0}) begin
            failures++;
            $display("[TB] FAIL fixed_wr_all got gnt=%b stall=%h want gnt=0001 stall=db0", oWrGnt[0], oStall[0]);
        end
        checks++;
        if (oWrGnt[1] !== eWrGnt[1] || oStall[1] !== eStall[1]) begin
            failures++;
            $display("[TB] FAIL rr_wr_all got gnt=%b stall=%h want gnt=%b stall=%h",
                     oWrGnt[1], oStall[1], eWrGnt[1], eStall[1]);
        end
        tick();
        wr_req = 4'b0000;
        rd_req = 4'b0110;
        #1;
        modelEval();
        checks++;
        if (oRdGnt[0] !== 4'b0010 || oStall[0][6 +: 3] !== 3'd4 || oStall[0][3 +: 3] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL fixed_rd got gnt=%b stall=%h want gnt=0010 stall2=4", oRdGnt[0], oStall[0]);
        end
        checks++;
        if (oRdGnt[1] !== eRdGnt[1] || oStall[1] !== eStall[1]) begin
            failures++;
            $display("[TB] FAIL rr_rd got gnt=%b stall=%h want gnt=%b stall=%h",
                     oRdGnt[1], oStall[1], eRdGnt[1], eStall[1]);
        end
        tick();
        wr_req = 4'b0100;
        rd_req = 4'b0011;
        #1;
        modelEval();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oWrGnt[m] !== eWrGnt[m] || oRdGnt[m] !== eRdGnt[m] || oStall[m] !== eStall[m]) begin
                failures++;
                $display("[TB] FAIL mixed_arb dut%0d got wr=%b rd=%b stall=%h want wr=%b rd=%b stall=%h",
                         m, oWrGnt[m], oRdGnt[m], oStall[m], eWrGnt[m], eRdGnt[m], eStall[m]);
            end
        end
        tick();
        clearInputs();
    endtask

    task automatic test_rr_arb();
        logic [N-1:0] seqA [5];
        logic [N-1:0] seqW [4];
        logic [N-1:0] seqR [4];
        seqA = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seqW = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
        seqR = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_req = 4'b1111;
            #1;
            checks++;
            if (oWrGnt[1] !== seqA[k] || oWrGnt[0] !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL rr_rotate step%0d got rr=%b fix=%b want rr=%b fix=0001",
                         k, oWrGnt[1], oWrGnt[0], seqA[k]);
            end
            tick();
        end
        wr_req = 4'b0000;
        pr_vld = 4'b0001;
        pr_tgt[0 +: 2] = 2'd2;
        tick();
        pr_vld = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr_req = 4'b1111;
            rd_req = 4'b1111;
            #1;
            checks++;
            if (oWrGnt[1] !== seqW[k] || oRdGnt[1] !== seqR[k]) begin
                failures++;
                $display("[TB] FAIL rr_skip_paused step%0d got wr=%b rd=%b want wr=%b rd=%b",
                         k, oWrGnt[1], oRdGnt[1], seqW[k], seqR[k]);
            end
            tick();
        end
        wr_req = 4'b0100;
        rd_req = 4'b0000;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oWrGnt[m] !== 4'b0000 || oStall[m][6 +: 3] !== 3'd6) begin
                failures++;
                $display("[TB] FAIL paused_request dut%0d got gnt=%b stall2=%0d want gnt=0000 stall2=6",
                         m, oWrGnt[m], oStall[m][6 +: 3]);
            end
        end
        tick();
        wr_req = 4'b1111;
        pr_vld = 4'b0001;
        pr_resume = 4'b0001;
        #1;
        modelEval();
        checks++;
        if (oWrGnt[1] !== eWrGnt[1]) begin
            failures++;
            $display("[TB] FAIL rr_ptr_hold got=%b want=%b", oWrGnt[1], eWrGnt[1]);
        end
        tick();
        clearInputs();
    endtask

    task automatic test_all_halt();
        awake  = 4'b0011;
        halted = 4'b0001;
        #1;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oAllHalt[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL halt_partial dut%0d got=%b want=0", m, oAllHalt[m]);
            end
        end
        halted = 4'b0011;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oAllHalt[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL halt_registered dut%0d got=%b want=0", m, oAllHalt[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oAllHalt[m] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL halt_rise dut%0d got=%b want=1", m, oAllHalt[m]);
            end
        end
        halted = 4'b0000;
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oAllHalt[m] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL halt_sticky dut%0d got=%b want=1", m, oAllHalt[m]);
            end
        end
        rst_n = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (oAllHalt[m] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL halt_reset_clear dut%0d got=%b want=0", m, oAllHalt[m]);
            end
        end
        rst_n = 1'b1;
        clearInputs();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            wake_vld  = N'($urandom);
            wake_tgt  = 8'($urandom);
            wake_pc   = {$urandom, $urandom};
            pr_vld    = N'($urandom);
            pr_resume = N'($urandom);
            pr_tgt    = 8'($urandom);
            wr_req    = N'($urandom);
            rd_req    = N'($urandom);
            awake     = N'($urandom) | N'($urandom);
            halted    = N'($urandom) & N'($urandom);
            #1;
            modelEval();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (oStartVld[m] !== eStartVld || oStartPc[m] !== eStartPc || oWakeAck[m] !== eWakeAck) begin
                    failures++;
                    $display("[TB] FAIL rand_wake cyc%0d dut%0d got vld=%b pc=%h ack=%b want vld=%b pc=%h ack=%b",
                             c, m, oStartVld[m], oStartPc[m], oWakeAck[m], eStartVld, eStartPc, eWakeAck);
                end
                checks++;
                if (oWrGnt[m] !== eWrGnt[m] || oRdGnt[m] !== eRdGnt[m] || oStall[m] !== eStall[m]) begin
                    failures++;
                    $display("[TB] FAIL rand_arb cyc%0d dut%0d got wr=%b rd=%b stall=%h want wr=%b rd=%b stall=%h",
                             c, m, oWrGnt[m], oRdGnt[m], oStall[m], eWrGnt[m], eRdGnt[m], eStall[m]);
                end
                checks++;
                if (oAllHalt[m] !== mAllHalt) begin
                    failures++;
                    $display("[TB] FAIL rand_all_halt cyc%0d dut%0d got=%b want=%b", c, m, oAllHalt[m], mAllHalt);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        clearInputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();
        @(negedge clk);
        test_reset();
        test_wake();
        test_pause_resume();
        test_fixed_arb();
        test_rr_arb();
        test_all_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
